// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD complementer family: FSM state encoding,
// the BCD digit limit and the complement-mode encoding.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam logic MODE_C9  = 1'b0;
  localparam logic MODE_C10 = 1'b1;

endpackage

// File: rtl/bcd_digit_comp.sv
// Single-digit BCD complement cell: 9 - d plus an incoming carry that is only
// honoured in 10's-complement mode. Non-BCD digits give 0 and kill the carry.
module bcd_digit_comp
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       mode,
  output logic [3:0] q,
  output logic       cout,
  output logic       bad
);

  logic       c_eff;
  logic [3:0] sum;

  // Complement one digit and resolve the decimal carry
  always_comb begin
    bad   = (d > BCD_NINE);
    c_eff = (mode == MODE_C10) ? cin : 1'b0;
    // 9 - d is at most 9 for a valid digit, so sum fits in 4 bits (max 10)
    sum   = (BCD_NINE - d) + {3'b000, c_eff};
    q     = sum;
    cout  = 1'b0;
    if (bad) begin
      q    = 4'd0;
      cout = 1'b0;
    end else if (sum == 4'd10) begin
      q    = 4'd0;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_comp_serial.sv
// Digit-serial BCD 9's/10's complementer. One digit per clock, LSD first;
// results enter at the MSD end of the result register so that after DIGITS
// shifts the result sits in packed order. Valid/ready on both sides.
module bcd_comp_serial
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic                  out_err,
  output logic                  out_cout
);

  localparam int W = 4 * DIGITS;

  state_e           state_q, state_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       dig_q;
  logic             dig_cout;
  logic             dig_bad;
  logic             last_digit;

  bcd_digit_comp u_digit (
    .d    (sh_q[3:0]),
    .cin  (carry_q),
    .mode (mode_q),
    .q    (dig_q),
    .cout (dig_cout),
    .bad  (dig_bad)
  );

  assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next-state: load on accept, shift one digit per RUN cycle
  always_comb begin
    sh_d    = sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && in_valid) begin
      sh_d    = in_data;
      mode_d  = in_mode;
      carry_d = in_mode;   // 10's complement = 9's complement + 1 at the LSD
      err_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      sh_d    = sh_q >> 4;
      res_d   = (res_q >> 4) | (W'(dig_q) << (W - 4));
      carry_d = dig_cout;
      err_d   = err_q | dig_bad;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= MODE_C9;
      cnt_q   <= '0;
    end else begin
      sh_q    <= sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data = res_q;
  assign out_err  = err_q;
  assign out_cout = carry_q;

endmodule

// File: tb/tb_bcd_comp_serial.sv
// Scoreboard bench for bcd_comp_serial (DIGITS=4): directed vectors with
// hand-derived results plus random operands checked against an arithmetic
// reference model; a monitor pops expectations on each output handshake.
module tb_bcd_comp_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         out_cout;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic         cout;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;
  bit   man_rdy  = 1'b0;

  bcd_comp_serial #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic e, input logic c);
    exp_t r;
    r.data = d;
    r.err  = e;
    r.cout = c;
    return r;
  endfunction

  // Reference: complement of the decimal value below the lowest bad digit,
  // bad digits become 0 and break the carry, digits above get 9 - d.
  function automatic exp_t model(input logic [W-1:0] x, input logic m);
    int   dg[D];
    int   kb = D;
    int   xl = 0;
    int   p = 1;
    int   lowres;
    logic carry;
    exp_t e;
    for (int i = 0; i < D; i++) dg[i] = int'(x[4*i +: 4]);
    for (int i = D - 1; i >= 0; i--) if (dg[i] > 9) kb = i;
    for (int i = 0; i < kb; i++) begin
      xl += dg[i] * p;
      p  *= 10;
    end
    if (m) begin
      lowres = (p - xl) % p;
      carry  = (xl == 0);
    end else begin
      lowres = p - 1 - xl;
      carry  = 1'b0;
    end
    e.data = '0;
    for (int i = 0; i < D; i++) begin
      int nd;
      if (i < kb) begin
        nd = lowres % 10;
        lowres = lowres / 10;
      end else begin
        nd = (dg[i] > 9) ? 0 : 9 - dg[i];
      end
      e.data[4*i +: 4] = 4'(nd);
    end
    e.err  = (kb < D);
    e.cout = (kb < D) ? 1'b0 : carry;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic m, input exp_t e);
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready %b, expected 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    @(posedge clk);
    q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
      q.delete();
    end
  endtask

  // Single driver of out_ready: random backpressure or manual level
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? (($urandom % 3) != 0) : man_rdy;
  end

  // Monitor: compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no output", out_data);
      end else begin
        mon_e = q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_err",  32'(out_err),  32'(mon_e.err));
        check("out_cout", 32'(out_cout), 32'(mon_e.cout));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 1'b0;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_out_cout",  32'(out_cout),  32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Latency: valid must rise exactly after the DIGITS-th processing edge
    send(16'h1234, 1'b0, mk(16'h8765, 1'b0, 1'b0));
    for (int i = 1; i <= D; i++) begin
      @(posedge clk); #2;
      check("latency_out_valid", 32'(out_valid), 32'(i == D));
      check("run_in_ready", 32'(in_ready), 32'd0);
    end
    man_rdy = 1'b1;
    @(posedge clk); #2;
    man_rdy = 1'b0;
    @(posedge clk); #2;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, no backpressure
    man_rdy = 1'b1;
    send(16'h1234, 1'b1, mk(16'h8766, 1'b0, 1'b0));
    send(16'h0990, 1'b1, mk(16'h9010, 1'b0, 1'b0));
    send(16'h0000, 1'b1, mk(16'h0000, 1'b0, 1'b1));
    send(16'h0000, 1'b0, mk(16'h9999, 1'b0, 1'b0));
    send(16'h12A4, 1'b0, mk(16'h8705, 1'b1, 1'b0));
    send(16'h0001, 1'b0, mk(16'h9998, 1'b0, 1'b0));
    send(16'h00B0, 1'b1, mk(16'h9900, 1'b1, 1'b0));
    drain();

    // Backpressure: result held for 10 cycles
    man_rdy = 1'b0;
    send(16'h4321, 1'b0, mk(16'h5678, 1'b0, 1'b0));
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #2;
        t++;
      end
    end
    check("hold_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data",  32'(out_data),  32'h5678);
      check("hold_in_ready",  32'(in_ready),  32'd0);
    end
    man_rdy = 1'b1;
    @(posedge clk); #2;
    man_rdy = 1'b0;
    @(posedge clk); #2;
    check("post_pulse_in_ready",  32'(in_ready),  32'd1);
    check("post_pulse_out_valid", 32'(out_valid), 32'd0);
    check("post_pulse_out_data",  32'(out_data),  32'h5678);

    // Reset two cycles into RUN discards the operation
    send(16'h1234, 1'b0, mk(16'h8765, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_out_err",   32'(out_err),   32'd0);
    check("midrst_out_cout",  32'(out_cout),  32'd0);
    q.delete(q.size() - 1);
    @(negedge clk) rst_n = 1'b1;
    man_rdy = 1'b1;
    send(16'h5000, 1'b1, mk(16'h5000, 1'b0, 1'b0));
    drain();

    // Random operands with random backpressure
    @(negedge clk) rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] x;
      logic         m;
      for (int i = 0; i < D; i++) begin
        int r;
        r = int'($urandom % 16);
        if (r >= 10 && ($urandom % 4) != 0) r = r % 10;
        if (($urandom % 8) == 0) r = 0;
        x[4*i +: 4] = 4'(r);
      end
      m = 1'($urandom % 2);
      send(x, m, model(x, m));
    end
    drain();
    @(negedge clk) rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
